// File: rtl/ysyx_22041207_store_unit.sv
`default_nettype none
// ============================================================================
// Module : ysyx_22041207_store_unit
// Brief  : Splits one store into one or two aligned, byte-masked 64-bit
//          write beats; rejects misaligned stores when ALLOW_MISALIGN==0.
// Rev    : 1.1
// ============================================================================

module ysyx_22041207_store_unit #(
    parameter int ADDR_W         = 64,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_wen,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wmask,
    output logic              resp_valid,
    output logic              resp_err
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_BEAT0 = 2'd1;
    localparam logic [1:0] c_S_BEAT1 = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [127:0]      r_data128;
    logic [15:0]       r_mask16;
    logic              r_err;

    logic [2:0]   w_off;
    logic [7:0]   w_byte_mask;
    logic [2:0]   w_align_mask;
    logic [63:0]  w_lane_data;
    logic [127:0] w_shifted_data;
    logic [15:0]  w_shifted_mask;
    logic         w_misaligned;

    always_comb begin
        w_off = req_addr[2:0];
        case (req_size)
            2'b00:   begin w_byte_mask = 8'h01; w_align_mask = 3'b000; end
            2'b01:   begin w_byte_mask = 8'h03; w_align_mask = 3'b001; end
            2'b10:   begin w_byte_mask = 8'h0F; w_align_mask = 3'b011; end
            default: begin w_byte_mask = 8'hFF; w_align_mask = 3'b111; end
        endcase
        w_shifted_data = {64'b0, w_lane_data} << {w_off, 3'b000};
        w_shifted_mask = {8'b0, w_byte_mask} << w_off;
        w_misaligned   = (w_off & w_align_mask) != 3'b000;
    end

    // Bytes beyond the store size are zeroed so unused lanes never carry stale data.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign w_lane_data[8*i +: 8] = req_data[8*i +: 8] & {8{w_byte_mask[i]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_S_IDLE;
            r_base    <= '0;
            r_data128 <= '0;
            r_mask16  <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (req_valid) begin
                        r_base    <= {req_addr[ADDR_W-1:3], 3'b000};
                        r_data128 <= w_shifted_data;
                        r_mask16  <= w_shifted_mask;
                        if (w_misaligned && !ALLOW_MISALIGN) begin
                            r_err   <= 1'b1;
                            r_state <= c_S_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= c_S_BEAT0;
                        end
                    end
                end
                c_S_BEAT0: begin
                    if (mem_ready) r_state <= (r_mask16[15:8] != 8'h00) ? c_S_BEAT1 : c_S_RESP;
                end
                c_S_BEAT1: begin
                    if (mem_ready) r_state <= c_S_RESP;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, never directly on req_*.
    always_comb begin
        req_ready  = (r_state == c_S_IDLE);
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (r_state)
            c_S_BEAT0: begin
                mem_wen   = 1'b1;
                mem_waddr = r_base;
                mem_wdata = r_data128[63:0];
                mem_wmask = r_mask16[7:0];
            end
            c_S_BEAT1: begin
                mem_wen   = 1'b1;
                mem_waddr = r_base + ADDR_W'(8);
                mem_wdata = r_data128[127:64];
                mem_wmask = r_mask16[15:8];
            end
            c_S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
